// File: rtl/ad5725_readback.sv
// AD5725 parallel-bus readback engine: single-channel or 4-channel scan reads.
// Optional compile macro READBACK_COMPARE_EN adds EXP_DATA_I/MISMATCH_O sticky compare.
module ad5725_readback #(
    parameter int unsigned SETUP_TIME   = 1,
    parameter int unsigned CS_HOLD_TIME = 3,
    parameter int unsigned RECOVER_TIME = 2
) (
    input  logic        FPGA_CLK_I,
    input  logic        RESET_N_I,
    input  logic        EN_I,
    input  logic        SCAN_I,
    input  logic [1:0]  ADDR_I,
    output logic        IDLE_O,
    output logic        BUS_REQ_O,
    output logic [11:0] DATA_O,
    output logic [1:0]  CH_O,
    output logic        VALID_O,
    output logic [1:0]  AD_O,
    input  logic [11:0] DB_I,
    output logic        RW_N_O,
    output logic        CS_N_O,
    output logic        LDAC_N_O,
    output logic        CLR_N_O
`ifdef READBACK_COMPARE_EN
   ,input  logic [47:0] EXP_DATA_I
   ,output logic        MISMATCH_O
`endif
);

    localparam logic [15:0] C_SETUP = (SETUP_TIME   == 0) ? 16'd1 : SETUP_TIME[15:0];
    localparam logic [15:0] C_HOLD  = (CS_HOLD_TIME == 0) ? 16'd1 : CS_HOLD_TIME[15:0];
    localparam logic [15:0] C_REC   = (RECOVER_TIME == 0) ? 16'd1 : RECOVER_TIME[15:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CS,
        S_SAMPLE,
        S_RECOVER
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_scan;
    logic [1:0]  r_chan;
    logic [1:0]  r_ad;
    logic        r_cs_n;
    logic        r_bus_req;
    logic        r_idle;
    logic [11:0] r_data;
    logic [1:0]  r_ch;
    logic        r_valid;

`ifdef READBACK_COMPARE_EN
    logic [11:0] w_exp;
    logic        r_mismatch;

    always_comb begin
        w_exp = EXP_DATA_I[11:0];
        case (r_chan)
            2'd0: w_exp = EXP_DATA_I[11:0];
            2'd1: w_exp = EXP_DATA_I[23:12];
            2'd2: w_exp = EXP_DATA_I[35:24];
            2'd3: w_exp = EXP_DATA_I[47:36];
            default: w_exp = EXP_DATA_I[11:0];
        endcase
    end

    assign MISMATCH_O = r_mismatch;
`endif

    always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
        if (!RESET_N_I) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_scan    <= 1'b0;
            r_chan    <= '0;
            r_ad      <= '0;
            r_cs_n    <= 1'b1;
            r_bus_req <= 1'b0;
            r_idle    <= 1'b1;
            r_data    <= '0;
            r_ch      <= '0;
            r_valid   <= 1'b0;
`ifdef READBACK_COMPARE_EN
            r_mismatch <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (EN_I) begin
                        r_scan    <= SCAN_I;
                        r_chan    <= SCAN_I ? 2'd0 : ADDR_I;
                        r_ad      <= SCAN_I ? 2'd0 : ADDR_I;
                        r_cnt     <= C_SETUP;
                        r_bus_req <= 1'b1;
                        r_idle    <= 1'b0;
                        r_state   <= S_SETUP;
`ifdef READBACK_COMPARE_EN
                        r_mismatch <= 1'b0;
`endif
                    end
                end
                S_SETUP: begin
                    if (r_cnt <= 16'd1) begin
                        r_cs_n  <= 1'b0;
                        r_cnt   <= C_HOLD;
                        r_state <= S_CS;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_CS: begin
                    if (r_cnt <= 16'd1) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_SAMPLE: begin
                    r_data  <= DB_I;
                    r_ch    <= r_chan;
                    r_valid <= 1'b1;
                    r_cs_n  <= 1'b1;
                    r_cnt   <= C_REC;
                    r_state <= S_RECOVER;
`ifdef READBACK_COMPARE_EN
                    if (DB_I != w_exp) r_mismatch <= 1'b1;
`endif
                end
                S_RECOVER: begin
                    if (r_cnt <= 16'd1) begin
                        if (r_scan && (r_chan != 2'd3)) begin
                            r_chan  <= r_chan + 2'd1;
                            r_ad    <= r_chan + 2'd1;
                            r_cnt   <= C_SETUP;
                            r_state <= S_SETUP;
                        end else begin
                            r_bus_req <= 1'b0;
                            r_idle    <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_cs_n    <= 1'b1;
                    r_bus_req <= 1'b0;
                    r_idle    <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign IDLE_O    = r_idle;
    assign BUS_REQ_O = r_bus_req;
    assign DATA_O    = r_data;
    assign CH_O      = r_ch;
    assign VALID_O   = r_valid;
    assign AD_O      = r_ad;
    assign CS_N_O    = r_cs_n;
    assign RW_N_O    = 1'b1;
    assign LDAC_N_O  = 1'b1;
    assign CLR_N_O   = 1'b1;

endmodule

// File: tb/tb_ad5725_readback.sv
// Randomized bench for ad5725_readback: default-parameter DUT and an all-zero-parameter DUT,
// checked cycle by cycle against a phase-list model of each read.
module tb_ad5725_readback;

    logic        clk;
    logic        rst_n;
    logic [1:0]  en;
    logic        scan;
    logic [1:0]  addr;
    logic [11:0] db;
    logic [47:0] exp_w;

    logic        idle_o  [2];
    logic        bus_o   [2];
    logic [11:0] data_o  [2];
    logic [1:0]  ch_o    [2];
    logic        valid_o [2];
    logic [1:0]  ad_o    [2];
    logic        rw_n_o  [2];
    logic        cs_n_o  [2];
    logic        ldac_o  [2];
    logic        clr_o   [2];
`ifdef READBACK_COMPARE_EN
    logic        mis_o   [2];
`endif

    int n_chk = 0;
    int n_err = 0;

    int          m_data [2];
    int          m_ch   [2];
    int          m_mis  [2];

    ad5725_readback u_dut_def (
        .FPGA_CLK_I (clk),
        .RESET_N_I  (rst_n),
        .EN_I       (en[0]),
        .SCAN_I     (scan),
        .ADDR_I     (addr),
        .IDLE_O     (idle_o[0]),
        .BUS_REQ_O  (bus_o[0]),
        .DATA_O     (data_o[0]),
        .CH_O       (ch_o[0]),
        .VALID_O    (valid_o[0]),
        .AD_O       (ad_o[0]),
        .DB_I       (db),
        .RW_N_O     (rw_n_o[0]),
        .CS_N_O     (cs_n_o[0]),
        .LDAC_N_O   (ldac_o[0]),
        .CLR_N_O    (clr_o[0])
`ifdef READBACK_COMPARE_EN
       ,.EXP_DATA_I (exp_w)
       ,.MISMATCH_O (mis_o[0])
`endif
    );

    ad5725_readback #(
        .SETUP_TIME   (0),
        .CS_HOLD_TIME (0),
        .RECOVER_TIME (0)
    ) u_dut_zero (
        .FPGA_CLK_I (clk),
        .RESET_N_I  (rst_n),
        .EN_I       (en[1]),
        .SCAN_I     (scan),
        .ADDR_I     (addr),
        .IDLE_O     (idle_o[1]),
        .BUS_REQ_O  (bus_o[1]),
        .DATA_O     (data_o[1]),
        .CH_O       (ch_o[1]),
        .VALID_O    (valid_o[1]),
        .AD_O       (ad_o[1]),
        .DB_I       (db),
        .RW_N_O     (rw_n_o[1]),
        .CS_N_O     (cs_n_o[1]),
        .LDAC_N_O   (ldac_o[1]),
        .CLR_N_O    (clr_o[1])
`ifdef READBACK_COMPARE_EN
       ,.EXP_DATA_I (exp_w)
       ,.MISMATCH_O (mis_o[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare every observable output of DUT d against the model for the current cycle.
    task automatic cyc(input int d, input bit e_cs, input bit e_bus, input bit e_valid, input int e_ad);
        check("cs_n",  32'(cs_n_o[d]),  32'(e_cs));
        check("busreq", 32'(bus_o[d]),  32'(e_bus));
        check("idle",  32'(idle_o[d]),  32'(!e_bus));
        check("valid", 32'(valid_o[d]), 32'(e_valid));
        check("rw_n",  32'(rw_n_o[d]),  32'd1);
        if (e_bus) check("ad", 32'(ad_o[d]), 32'(e_ad));
        check("data",  32'(data_o[d]),  32'(m_data[d]));
        check("ch",    32'(ch_o[d]),    32'(m_ch[d]));
`ifdef READBACK_COMPARE_EN
        check("mismatch", 32'(mis_o[d]), 32'(m_mis[d]));
`endif
    endtask

    task automatic junk(input int d);
        en[d] = 1'($urandom_range(0, 1));
        scan  = 1'($urandom_range(0, 1));
        addr  = 2'($urandom_range(0, 3));
        db    = 12'($urandom);
    endtask

    task automatic idle_cycles(input int d, input int n);
        en = '0;
        for (int i = 0; i < n; i++) begin
            db = 12'($urandom);
            cyc(d, 1'b1, 1'b0, 1'b0, 0);
            advance();
        end
    endtask

    // One read transaction as a list of phases. Called at a negedge while DUT d is idle.
    // force_db: -1 random (half the time matching exp_w), -2 returns 0x100+channel, else that value.
    task automatic walk(input int d, input bit sc, input logic [1:0] a, input int force_db,
                        input int abort_ch, input bit keep);
        int s_len, h_len, r_len, first, last;
        logic [11:0] dbv;
        s_len = (d == 0) ? 1 : 1;
        h_len = (d == 0) ? 3 : 1;
        r_len = (d == 0) ? 2 : 1;
        en = '0;
        en[d] = 1'b1;
        scan = sc;
        addr = a;
        db = 12'($urandom);
        advance();
        m_mis[d] = 0;
        first = sc ? 0 : int'(a);
        last  = sc ? 3 : int'(a);
        for (int ch = first; ch <= last; ch++) begin
            for (int i = 0; i < s_len; i++) begin
                cyc(d, 1'b1, 1'b1, 1'b0, ch);
                junk(d);
                advance();
            end
            for (int i = 0; i < h_len + 1; i++) begin
                cyc(d, 1'b0, 1'b1, 1'b0, ch);
                if (ch == abort_ch && i == 1) begin
                    rst_n = 1'b0;
                    #1;
                    for (int k = 0; k < 2; k++) begin
                        m_data[k] = 0;
                        m_ch[k]   = 0;
                        m_mis[k]  = 0;
                    end
                    check("rst_cs_n",  32'(cs_n_o[d]),  32'd1);
                    check("rst_busreq", 32'(bus_o[d]),  32'd0);
                    check("rst_valid", 32'(valid_o[d]), 32'd0);
                    check("rst_data",  32'(data_o[d]),  32'd0);
                    check("rst_idle",  32'(idle_o[d]),  32'd1);
                    en = '0;
                    #2;
                    rst_n = 1'b1;
                    @(negedge clk);
                    return;
                end
                junk(d);
                if (i == h_len) begin
                    if (force_db == -2)      dbv = 12'(32'h100 + ch);
                    else if (force_db >= 0)  dbv = 12'(force_db);
                    else if ($urandom_range(0, 1) == 1) dbv = exp_w[ch*12 +: 12];
                    else                     dbv = 12'($urandom);
                    db = dbv;
                    m_data[d] = int'(dbv);
                    m_ch[d]   = ch;
                    if (dbv != exp_w[ch*12 +: 12]) m_mis[d] = 1;
                end
                advance();
            end
            for (int i = 0; i < r_len; i++) begin
                cyc(d, 1'b1, 1'b1, (i == 0), ch);
                junk(d);
                if (ch == last && i == r_len - 1) en[d] = keep;
                advance();
            end
        end
        cyc(d, 1'b1, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = '0;
        scan  = 1'b0;
        addr  = '0;
        db    = '0;
        exp_w = {$urandom, $urandom};
        for (int k = 0; k < 2; k++) begin
            m_data[k] = 0;
            m_ch[k]   = 0;
            m_mis[k]  = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cyc(k, 1'b1, 1'b0, 1'b0, 0);
            check("rst_ad",   32'(ad_o[k]),   32'd0);
            check("rst_ldac", 32'(ldac_o[k]), 32'd1);
            check("rst_clr",  32'(clr_o[k]),  32'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        walk(0, 1'b0, 2'd2, 12'hA5C, -1, 1'b0);
        idle_cycles(0, 3);
        walk(0, 1'b1, 2'd0, -2, -1, 1'b0);
        idle_cycles(0, 5);
        walk(1, 1'b0, 2'd3, -1, -1, 1'b0);
        idle_cycles(1, 2);
        walk(1, 1'b1, 2'd0, -2, -1, 1'b0);
        idle_cycles(1, 3);

        walk(0, 1'b1, 2'd0, -2, 1, 1'b0);
        idle_cycles(0, 3);
        walk(0, 1'b0, 2'd1, -1, -1, 1'b0);
        idle_cycles(0, 2);

        walk(0, 1'b0, 2'd0, -1, -1, 1'b1);
        walk(0, 1'b1, 2'd0, -1, -1, 1'b1);
        walk(0, 1'b0, 2'd3, -1, -1, 1'b0);
        idle_cycles(0, 2);

        exp_w[23:12] = 12'h123;
        walk(0, 1'b0, 2'd1, 12'h124, -1, 1'b0);
        idle_cycles(0, 4);
        walk(0, 1'b0, 2'd1, 12'h123, -1, 1'b0);
        idle_cycles(0, 2);

        for (int t = 0; t < 24; t++) begin
            int d;
            d = $urandom_range(0, 1);
            exp_w = {$urandom, $urandom};
            walk(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), -1, -1, 1'b0);
            idle_cycles(d, $urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ad5725_readback.md
Name: ad5725_readback

Overview:
Parallel-bus reader for the AD5725 quad 12-bit DAC. It reads back DAC input-register contents over the shared AD/DB/RW/CS bus, either one channel or a scan of all four, so firmware can verify what was written. It sits beside the DAC write controller behind the top-level bus mux. While BUS_REQ_O is high, the mux routes this block's control lines to the pins and tristates the FPGA's DB drivers.

Parameters:
SETUP_TIME, 1, cycles AD_O/RW_N_O are held stable with CS_N_O high before the CS_N_O fall (0 treated as 1)
CS_HOLD_TIME, 3, cycles CS_N_O is held low before DB_I is sampled, covering DAC access time (0 treated as 1)
RECOVER_TIME, 2, cycles CS_N_O is held high after a read before the next read or IDLE (0 treated as 1)

Ports:
FPGA_CLK_I  in  1  system clock, 100 MHz
RESET_N_I  in  1  reset, asynchronous, active-low
EN_I  in  1  start request; sampled only in IDLE
SCAN_I  in  1  sampled with EN_I; 1 = read channels 0..3 in order, 0 = read ADDR_I only
ADDR_I  in  2  channel for a single read; sampled with EN_I
IDLE_O  out  1  high only in IDLE
BUS_REQ_O  out  1  high in every non-IDLE state
DATA_O  out  12  last captured readback word
CH_O  out  2  channel of DATA_O
VALID_O  out  1  one-cycle pulse: DATA_O/CH_O are new
AD_O  out  2  AD5725 address
DB_I  in  12  AD5725 data bus, input direction
RW_N_O  out  1  AD5725 R/W; 1 = read
CS_N_O  out  1  AD5725 chip select
LDAC_N_O  out  1  held 1
CLR_N_O  out  1  held 1
EXP_DATA_I, MISMATCH_O  (optional feature only, see below)

Behaviour:
- Reset (async, any state): FSM goes to IDLE. AD_O=0, RW_N_O=1, CS_N_O=1, LDAC_N_O=1, CLR_N_O=1, BUS_REQ_O=0, DATA_O=0, CH_O=0, VALID_O=0. An in-flight read is discarded and produces no VALID_O.
- States: IDLE, SETUP, CS, SAMPLE, RECOVER. All outputs are registered. The values listed below are the ones visible on the pins while the FSM is in that state.
- IDLE: CS_N_O=1, RW_N_O=1, BUS_REQ_O=0. If EN_I=1, latch SCAN_I and set channel = SCAN_I ? 0 : ADDR_I, then go to SETUP.
- SETUP: AD_O=channel, RW_N_O=1, CS_N_O=1, BUS_REQ_O=1. Lasts SETUP_TIME cycles, then go to CS.
- CS: CS_N_O=0, AD_O/RW_N_O stable. Lasts CS_HOLD_TIME cycles, then go to SAMPLE.
- SAMPLE: CS_N_O=0 for one more cycle. DB_I is registered into DATA_O at the end of this cycle and CH_O=channel. Next state is RECOVER.
- RECOVER: CS_N_O=1, RW_N_O=1, BUS_REQ_O=1. VALID_O=1 in the first RECOVER cycle only. Lasts RECOVER_TIME cycles. Then:
  - if scan and channel<3: channel+1, go to SETUP;
  - otherwise go to IDLE.
- Single-read latency with default parameters: EN_I high in cycle 0 gives SETUP in cycle 1, CS in cycles 2-4, SAMPLE in cycle 5, VALID_O in cycle 6, IDLE in cycle 8.
- CS_N_O is low for CS_HOLD_TIME+1 consecutive cycles per read.
- AD_O never changes while CS_N_O=0.
- Scan: 4 VALID_O pulses, CH_O = 0,1,2,3. Channel never wraps past 3.
- EN_I, SCAN_I and ADDR_I are ignored outside IDLE, including during RECOVER of a scan.
- EN_I held high continuously: a new read starts on each IDLE cycle, so there is exactly one IDLE cycle between back-to-back reads.
- Counters are 16 bit and load max(param,1) on state entry.
- DATA_O and CH_O hold their value until the next capture.
- DB_I is ignored in every state except SAMPLE.

Optional Feature:
Macro READBACK_COMPARE_EN.
- Defined: adds port EXP_DATA_I (in, 48, channel n at bits [12n+11:12n]) and port MISMATCH_O (out, 1, sticky).
  - In SAMPLE, if DB_I differs from the expected word for that channel, MISMATCH_O is set the same cycle VALID_O rises.
  - MISMATCH_O is cleared only on the IDLE→SETUP transition of a new EN_I start, or by reset.
- Undefined: neither port exists and there is no compare logic.

Test Plan:
- Single read, defaults: ADDR_I=2, SCAN_I=0, DB_I=0xA5C, EN_I pulse in cycle 0 -> AD_O=2, CS_N_O low in cycles 2-5 only, VALID_O in cycle 6 with DATA_O=0xA5C and CH_O=2, IDLE_O back in cycle 8.
- Scan: SCAN_I=1, DB_I model returns 0x100+channel -> 4 VALID_O pulses with (CH_O,DATA_O) = (0,0x100), (1,0x101), (2,0x102), (3,0x103); no fifth CS_N_O fall.
- Parameters at 0 (SETUP_TIME=CS_HOLD_TIME=RECOVER_TIME=0) -> same timing as all set to 1; CS_N_O low exactly 2 cycles.
- Reset asserted while in CS during a scan at channel 1 -> CS_N_O=1 and BUS_REQ_O=0 immediately, no VALID_O, DATA_O=0; the next EN_I pulse performs a normal read.
- EN_I toggled during an active read, and DB_I changed outside SAMPLE -> no restart, and the captured value is the one present in SAMPLE.
- READBACK_COMPARE_EN defined, EXP_DATA_I ch1=0x123, DB_I=0x124 -> MISMATCH_O rises with VALID_O and stays high; it clears on the next EN_I start.
